// File: rtl/proc_controller_pkg.sv
//------------------------------------------------------------------------------
// Module   : proc_pkg
// Brief    : Shared constants for the 16-bit lab processor control path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package proc_pkg;

    localparam int STATE_W = 4;
    localparam int OPC_W   = 4;
    localparam int ALU_W   = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [OPC_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h1;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'h5;

    localparam logic [STATE_W-1:0] S_INIT   = 4'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 4'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 4'd2;
    localparam logic [STATE_W-1:0] S_NOOP   = 4'd3;
    localparam logic [STATE_W-1:0] S_LOAD_A = 4'd4;
    localparam logic [STATE_W-1:0] S_LOAD_B = 4'd5;
    localparam logic [STATE_W-1:0] S_STORE  = 4'd6;
    localparam logic [STATE_W-1:0] S_ADD    = 4'd7;
    localparam logic [STATE_W-1:0] S_SUB    = 4'd8;
    localparam logic [STATE_W-1:0] S_HALT   = 4'd9;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

    // Operand field positions within IR[11:0]
    localparam int RA_LSB      = 8;
    localparam int RB_LSB      = 4;
    localparam int RD_LSB      = 0;
    localparam int LD_ADDR_LSB = 4;
    localparam int ST_ADDR_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/proc_controller_if.sv
//------------------------------------------------------------------------------
// Module   : proc_controller_if
// Brief    : Controller-to-datapath bundle; Step exists only with PROC_CTRL_STEP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface proc_controller_if
    import proc_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
);

    logic [IR_W-1:0]      IR;
    logic                 PC_clr;
    logic                 PC_up;
    logic                 IR_ld;
    logic [D_ADDR_W-1:0]  D_addr;
    logic                 D_wr;
    logic                 RF_s;
    logic [RF_ADDR_W-1:0] RF_W_addr;
    logic                 RF_W_en;
    logic [RF_ADDR_W-1:0] RF_Ra_addr;
    logic [RF_ADDR_W-1:0] RF_Rb_addr;
    logic                 RF_Ra_en;
    logic                 RF_Rb_en;
    logic [ALU_W-1:0]     ALU_s0;
    logic [STATE_W-1:0]   State;
`ifdef PROC_CTRL_STEP_EN
    logic                 Step;

    modport master (
        input  IR, Step,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_s0, State
    );
    modport slave (
        output IR, Step,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_s0, State
    );
`else
    modport master (
        input  IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_s0, State
    );
    modport slave (
        output IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_s0, State
    );
`endif

endinterface

`default_nettype wire

// File: rtl/proc_ctrl_outdec.sv
//------------------------------------------------------------------------------
// Module   : proc_ctrl_outdec
// Brief    : Moore output decode: state plus IR operand fields to all strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_ctrl_outdec
    import proc_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
)(
    input  logic [STATE_W-1:0]     state_i,
    input  logic [IR_W-OPC_W-1:0]  operand_i,
    input  logic                   fetch_go_i,
    output logic                   pc_clr_o,
    output logic                   pc_up_o,
    output logic                   ir_ld_o,
    output logic [D_ADDR_W-1:0]    d_addr_o,
    output logic                   d_wr_o,
    output logic                   rf_s_o,
    output logic [RF_ADDR_W-1:0]   rf_w_addr_o,
    output logic                   rf_w_en_o,
    output logic [RF_ADDR_W-1:0]   rf_ra_addr_o,
    output logic [RF_ADDR_W-1:0]   rf_rb_addr_o,
    output logic                   rf_ra_en_o,
    output logic                   rf_rb_en_o,
    output logic [ALU_W-1:0]       alu_s0_o
);

    always_comb begin
        pc_clr_o     = 1'b0;
        pc_up_o      = 1'b0;
        ir_ld_o      = 1'b0;
        d_addr_o     = '0;
        d_wr_o       = 1'b0;
        rf_s_o       = 1'b0;
        rf_w_addr_o  = '0;
        rf_w_en_o    = 1'b0;
        rf_ra_addr_o = '0;
        rf_rb_addr_o = '0;
        rf_ra_en_o   = 1'b0;
        rf_rb_en_o   = 1'b0;
        alu_s0_o     = ALU_PASS;
        case (state_i)
            S_INIT: begin
                pc_clr_o = 1'b1;
            end
            S_FETCH: begin
                ir_ld_o = fetch_go_i;
                pc_up_o = fetch_go_i;
            end
            // LOAD_A only waits out the synchronous RAM read; LOAD_B commits it
            S_LOAD_A, S_LOAD_B: begin
                d_addr_o    = operand_i[LD_ADDR_LSB +: D_ADDR_W];
                rf_s_o      = 1'b1;
                rf_w_addr_o = operand_i[RD_LSB +: RF_ADDR_W];
                rf_w_en_o   = (state_i == S_LOAD_B);
            end
            S_STORE: begin
                d_addr_o     = operand_i[ST_ADDR_LSB +: D_ADDR_W];
                d_wr_o       = 1'b1;
                rf_ra_addr_o = operand_i[RA_LSB +: RF_ADDR_W];
                rf_ra_en_o   = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr_o = operand_i[RA_LSB +: RF_ADDR_W];
                rf_rb_addr_o = operand_i[RB_LSB +: RF_ADDR_W];
                rf_ra_en_o   = 1'b1;
                rf_rb_en_o   = 1'b1;
                rf_w_addr_o  = operand_i[RD_LSB +: RF_ADDR_W];
                rf_w_en_o    = 1'b1;
                alu_s0_o     = (state_i == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/proc_controller.sv
//------------------------------------------------------------------------------
// Module   : proc_controller
// Brief    : Fetch/decode/execute FSM for the lab processor; PROC_CTRL_STEP_EN adds single-step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module proc_controller
    import proc_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
)(
    input  logic              Clk,
    input  logic              Rst,
    proc_controller_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [OPC_W-1:0]   opcode;
    logic               fetch_go;

    assign opcode = bus.IR[IR_W-1 -: OPC_W];

`ifdef PROC_CTRL_STEP_EN
    assign fetch_go = bus.Step;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = fetch_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_HALT;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.State = state_q;

    proc_ctrl_outdec #(
        .IR_W      (IR_W),
        .D_ADDR_W  (D_ADDR_W),
        .RF_ADDR_W (RF_ADDR_W)
    ) u_outdec (
        .state_i      (state_q),
        .operand_i    (bus.IR[IR_W-OPC_W-1:0]),
        .fetch_go_i   (fetch_go),
        .pc_clr_o     (bus.PC_clr),
        .pc_up_o      (bus.PC_up),
        .ir_ld_o      (bus.IR_ld),
        .d_addr_o     (bus.D_addr),
        .d_wr_o       (bus.D_wr),
        .rf_s_o       (bus.RF_s),
        .rf_w_addr_o  (bus.RF_W_addr),
        .rf_w_en_o    (bus.RF_W_en),
        .rf_ra_addr_o (bus.RF_Ra_addr),
        .rf_rb_addr_o (bus.RF_Rb_addr),
        .rf_ra_en_o   (bus.RF_Ra_en),
        .rf_rb_en_o   (bus.RF_Rb_en),
        .alu_s0_o     (bus.ALU_s0)
    );

endmodule

`default_nettype wire

// File: tb/tb_proc_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_proc_controller
// Brief    : Cycle-by-cycle scoreboard bench for proc_controller (PROC_CTRL_STEP_EN aware).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_proc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] wa;
        logic       we;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rae;
        logic       rbe;
        logic [2:0] alu;
    } exp_t;

    typedef struct {
        string      name;
        logic [15:0] ir;
        int         n_exec;
        exp_t       e1;
        exp_t       e2;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] pend_ir;
    exp_t sb[$];
    vec_t vecs[9];

    proc_controller_if bus ();

    proc_controller dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [3:0] st, input logic pc_clr, input logic pc_up,
                                input logic ir_ld, input logic [7:0] d_addr, input logic d_wr,
                                input logic rf_s, input logic [3:0] wa, input logic we,
                                input logic [3:0] ra, input logic [3:0] rb, input logic rae,
                                input logic rbe, input logic [2:0] alu);
        exp_t e;
        e.st = st; e.pc_clr = pc_clr; e.pc_up = pc_up; e.ir_ld = ir_ld;
        e.d_addr = d_addr; e.d_wr = d_wr; e.rf_s = rf_s; e.wa = wa; e.we = we;
        e.ra = ra; e.rb = rb; e.rae = rae; e.rbe = rbe; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t idle(input logic [3:0] st);
        return mk(st, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'b000);
    endfunction

    function automatic exp_t e_init();
        return mk(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'b000);
    endfunction

    function automatic exp_t e_fetch();
        return mk(4'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'b000);
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st = bus.State; a.pc_clr = bus.PC_clr; a.pc_up = bus.PC_up; a.ir_ld = bus.IR_ld;
        a.d_addr = bus.D_addr; a.d_wr = bus.D_wr; a.rf_s = bus.RF_s; a.wa = bus.RF_W_addr;
        a.we = bus.RF_W_en; a.ra = bus.RF_Ra_addr; a.rb = bus.RF_Rb_addr;
        a.rae = bus.RF_Ra_en; a.rbe = bus.RF_Rb_en; a.alu = bus.ALU_s0;
        return a;
    endfunction

    task automatic direct_chk(input string nm, input exp_t e);
        exp_t a;
        a = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic run(input int n, input string nm);
        exp_t e;
        exp_t a;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard empty got_state=%0d", nm, bus.State);
            end else begin
                e = sb.pop_front();
                a = sample();
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s state_exp=%0d got=%h exp=%h", nm, e.st, a, e);
                end
                if (e.st == 4'd1) bus.IR = pend_ir;
            end
        end
    endtask

    task automatic push_instr(input logic [15:0] ir, input int n_exec, input exp_t e1, input exp_t e2);
        pend_ir = ir;
        sb.push_back(e_fetch());
        sb.push_back(idle(4'd2));
        sb.push_back(e1);
        if (n_exec > 1) sb.push_back(e2);
    endtask

    task automatic reset_now(input string nm);
        #1 rst_n = 1'b0;
        #1 direct_chk(nm, e_init());
    endtask

    task automatic release_reset(input string nm);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(e_init());
        run(1, nm);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.IR  = 16'h0000;
        pend_ir = 16'h0000;
`ifdef PROC_CTRL_STEP_EN
        bus.Step = 1'b1;
`endif

        vecs[0] = '{"add_3125", 16'h3125, 1,
                    mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h5, 1, 4'h1, 4'h2, 1, 1, 3'b001), idle(4'd0)};
        vecs[1] = '{"sub_4A1B", 16'h4A1B, 1,
                    mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'hB, 1, 4'hA, 4'h1, 1, 1, 3'b010), idle(4'd0)};
        vecs[2] = '{"add_3333", 16'h3333, 1,
                    mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h3, 1, 4'h3, 4'h3, 1, 1, 3'b001), idle(4'd0)};
        vecs[3] = '{"load_2A47", 16'h2A47, 2,
                    mk(4'd4, 0, 0, 0, 8'hA4, 0, 1, 4'h7, 0, 4'h0, 4'h0, 0, 0, 3'b000),
                    mk(4'd5, 0, 0, 0, 8'hA4, 0, 1, 4'h7, 1, 4'h0, 4'h0, 0, 0, 3'b000)};
        vecs[4] = '{"store_1C3F", 16'h1C3F, 1,
                    mk(4'd6, 0, 0, 0, 8'h3F, 1, 0, 4'h0, 0, 4'hC, 4'h0, 1, 0, 3'b000), idle(4'd0)};
        vecs[5] = '{"noop_0ABC", 16'h0ABC, 1, idle(4'd3), idle(4'd0)};
        vecs[6] = '{"load_2FF0", 16'h2FF0, 2,
                    mk(4'd4, 0, 0, 0, 8'hFF, 0, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 3'b000),
                    mk(4'd5, 0, 0, 0, 8'hFF, 0, 1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 3'b000)};
        vecs[7] = '{"store_1000", 16'h1000, 1,
                    mk(4'd6, 0, 0, 0, 8'h00, 1, 0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 3'b000), idle(4'd0)};
        vecs[8] = '{"sub_4FFF", 16'h4FFF, 1,
                    mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'hF, 1, 4'hF, 4'hF, 1, 1, 3'b010), idle(4'd0)};

        repeat (2) @(negedge clk);
        direct_chk("reset_state", e_init());
        release_reset("init_one_cycle");

        for (int i = 0; i < 9; i++) begin
            push_instr(vecs[i].ir, vecs[i].n_exec, vecs[i].e1, vecs[i].e2);
            run(2 + vecs[i].n_exec, vecs[i].name);
        end

        // Reset in the middle of ADD must kill the write strobe without a clock edge
        push_instr(vecs[0].ir, 1, vecs[0].e1, idle(4'd0));
        run(3, "add_before_rst");
        reset_now("rst_mid_add");
        release_reset("init_after_add_rst");

        push_instr(vecs[3].ir, 1, vecs[3].e1, idle(4'd0));
        run(3, "load_a_before_rst");
        reset_now("rst_mid_load_a");
        sb.push_back(e_init());
        sb.push_back(e_init());
        run(2, "load_rst_held");
        release_reset("init_after_load_rst");

        push_instr(vecs[4].ir, 1, vecs[4].e1, idle(4'd0));
        run(3, "store_before_rst");
        reset_now("rst_mid_store");
        release_reset("init_after_store_rst");

        push_instr(16'h5000, 1, idle(4'd9), idle(4'd0));
        repeat (21) sb.push_back(idle(4'd9));
        run(24, "halt_5000");
        reset_now("rst_from_halt");
        release_reset("init_after_halt");

        push_instr(16'hF123, 1, idle(4'd9), idle(4'd0));
        repeat (21) sb.push_back(idle(4'd9));
        run(24, "halt_illegal_F123");
        reset_now("rst_from_illegal");

`ifdef PROC_CTRL_STEP_EN
        bus.Step = 1'b0;
        release_reset("init_before_step");
        repeat (10) sb.push_back(idle(4'd1));
        run(10, "fetch_wait_step");
        @(posedge clk);
        #1 bus.Step = 1'b1;
        pend_ir = 16'h0000;
        sb.push_back(e_fetch());
        run(1, "step_pulse_fetch");
        @(posedge clk);
        #1 bus.Step = 1'b0;
        sb.push_back(idle(4'd2));
        sb.push_back(idle(4'd3));
        repeat (3) sb.push_back(idle(4'd1));
        run(5, "after_step_pulse");
`else
        release_reset("init_after_illegal");
        push_instr(vecs[5].ir, 1, vecs[5].e1, idle(4'd0));
        sb.push_back(e_fetch());
        run(4, "noop_after_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/proc_controller.md
Name: proc_controller

Overview:
- Moore-style control FSM for the 16-bit lab processor. It sits directly upstream of the register file and drives its write and read ports.
- It fetches through the PC/IR handshake, decodes IR[15:12], and sequences the data-memory, register-file and ALU strobes for each instruction.
- All datapath modules (PC, IR, data RAM, register file, ALU, write-back mux) are external.

Parameters:
- IR_W, 16, instruction width
- D_ADDR_W, 8, data-memory address width
- RF_ADDR_W, 4, register-file address width (16 registers)

Ports:
- Clk, input, 1, system clock; all state changes on rising edge
- Rst, input, 1, asynchronous active-low reset; 0 forces the Init state immediately
- IR, input, IR_W, current instruction from the instruction register
- PC_clr, output, 1, clear program counter
- PC_up, output, 1, increment program counter
- IR_ld, output, 1, load instruction register from instruction memory
- D_addr, output, D_ADDR_W, data-memory address
- D_wr, output, 1, data-memory write enable
- RF_s, output, 1, write-back mux select (1 = data memory, 0 = ALU)
- RF_W_addr, output, RF_ADDR_W, register-file write address
- RF_W_en, output, 1, register-file write enable
- RF_Ra_addr, output, RF_ADDR_W, register-file A read address
- RF_Rb_addr, output, RF_ADDR_W, register-file B read address
- RF_Ra_en, output, 1, A-side read enable
- RF_Rb_en, output, 1, B-side read enable
- ALU_s0, output, 3, ALU function (000 pass/none, 001 add, 010 sub)
- State, output, 4, current state encoding, for debug and bench

Behaviour:
- **Reset.** One clock, Clk. Rst is asynchronous active-low; Rst=0 sets state=INIT at any time, including mid-instruction.
- **Outputs.**
  - All outputs are combinational decodes of the state register plus IR fields. No output depends on Rst directly.
  - While in reset or INIT: PC_clr=1. Every other strobe is 0, all address outputs are 0, and ALU_s0=000.
  - Any strobe not listed for a state is 0.
- **State encoding (4 bits):** INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- **Transitions:**
  - INIT -> FETCH; PC_clr=1.
  - FETCH -> DECODE; IR_ld=1, PC_up=1. IR holds the new instruction from the next edge.
  - DECODE: no strobes. Next state by IR[15:12]:
    - 0000 -> NOOP
    - 0001 -> STORE
    - 0010 -> LOAD_A
    - 0011 -> ADD
    - 0100 -> SUB
    - 0101 -> HALT
    - 0110–1111 -> HALT (illegal opcode is fatal)
  - NOOP -> FETCH.
  - LOAD_A -> LOAD_B; D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0. This is the synchronous-RAM read latency cycle.
  - LOAD_B -> FETCH; same addresses as LOAD_A, RF_s=1, RF_W_en=1.
  - STORE -> FETCH; D_addr=IR[7:0], D_wr=1, RF_Ra_addr=IR[11:8], RF_Ra_en=1.
  - ADD -> FETCH; RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_Ra_en=RF_Rb_en=1, RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=001.
  - SUB: as ADD, except ALU_s0=010.
  - HALT -> HALT forever; all strobes 0. Only Rst leaves it.
- **Timing.**
  - Instruction latency, FETCH to next FETCH: NOOP, ADD, SUB, STORE take 3 clocks; LOAD takes 4.
  - Write-enable strobes (RF_W_en, D_wr) are asserted for exactly one cycle per instruction.
  - A destination equal to a source register (e.g. ADD R3,R3,R3) is legal. The register file samples the write at the end of the cycle, so reads see the old value.
- **Boundaries.**
  - Rst asserted during LOAD_A: no register write occurs.
  - Rst asserted during STORE: D_wr drops combinationally with the state change.
  - IR is not re-sampled except in FETCH. IR changing outside FETCH is a datapath bug, not a controller concern.

Optional Feature:
- Macro: PROC_CTRL_STEP_EN.
- With the macro defined:
  - Adds input port Step (1 bit, synchronous pulse).
  - FETCH waits until Step=1 before moving to DECODE. IR_ld and PC_up are asserted only in the cycle where Step=1, so PC advances exactly one per pulse.
  - Step held high for several cycles executes one instruction per FETCH visit.
- Without the macro: no Step port; FETCH always advances after one cycle.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT
  - state localparams S_INIT through S_HALT
  - ALU function codes ALU_PASS, ALU_ADD, ALU_SUB
  - field-slice positions for IR
- The register file and ALU also consume the ALU and width constants from proc_pkg.
- One sub-module is natural: proc_ctrl_outdec, a purely combinational map of state plus IR to all outputs. The FSM register and next-state logic stay in proc_controller.

Test Plan:
1. **Reset:** Rst=0 mid-ADD → State=0, PC_clr=1, RF_W_en=0 immediately without a clock edge. Release Rst → FETCH on 2nd edge, i.e. INIT for one cycle.
2. **ADD:** IR=16'h3125 → in ADD state: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=5, RF_W_en=1, ALU_s0=001, RF_s=0. Next state FETCH, 3 clocks total.
3. **LOAD:** IR=16'h2A47 → LOAD_A: D_addr=8'hA4, RF_W_addr=7, RF_W_en=0, RF_s=1. LOAD_B: RF_W_en=1 for exactly 1 cycle.
4. **STORE:** IR=16'h1C3F → D_addr=8'h3F, D_wr=1, RF_Ra_addr=12, RF_Ra_en=1. No RF_W_en in any cycle.
5. **HALT / illegal:** IR=16'h5000 and IR=16'hF123 → State=9 and stays there 20+ cycles with all strobes 0. Rst pulse returns to INIT.
6. **Step (PROC_CTRL_STEP_EN):**
   - Step=0 for 10 cycles → State stays 1 (FETCH), PC_up=0 throughout.
   - A single Step pulse → exactly one PC_up and one IR_ld.
